// File: rtl/uart_fx_packet_engine.sv
// rtl/uart_fx_packet_engine.sv - UART byte-stream packet engine with per-packet effect and buffered echo
module uart_fx_packet_engine #(
  parameter logic [7:0] HEADER_BYTE = 8'hAA,
  parameter int         PAYLOAD_LEN = 4,
  parameter int         FIFO_DEPTH  = 16
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic                                         i_rx_dv,
  input  logic [7:0]                                   i_rx_byte,
  output logic                                         o_tx_dv,
  output logic [7:0]                                   o_tx_byte,
  input  logic                                         i_tx_active,
  input  logic                                         i_tx_done,
  input  logic [1:0]                                   i_mode,
  input  logic [7:0]                                   i_clip_level,
  input  logic [2:0]                                   i_crush_bits,
  output logic                                         o_overflow,
  output logic [$clog2(FIFO_DEPTH/PAYLOAD_LEN):0]      o_pkt_pending,
  output logic                                         o_busy
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PTRW = AW + 1;
  localparam int PW   = $clog2(FIFO_DEPTH / PAYLOAD_LEN) + 1;
  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);
  localparam logic [7:0] LEN8     = 8'(PAYLOAD_LEN);

  typedef enum logic {RX_WAIT_HDR, RX_PAYLOAD} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_HDR, TX_WAIT_HDR, TX_DATA, TX_WAIT_DATA} tx_state_t;

  rx_state_t rx_state_q, rx_state_d;
  tx_state_t tx_state_q, tx_state_d;
  logic [7:0]      rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [7:0]      clip_q, clip_d, tx_byte_q, tx_byte_d;
  logic [2:0]      crush_q, crush_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, pkt_start_q, pkt_start_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pending_q, pending_d;
  logic            done_prev_q, overflow_q, overflow_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, commit, tx_start, tx_dv, fifo_full, done_rise, is_hdr;
  logic [7:0]      fx_byte;

  // Extra MSB on the pointers separates full from empty.
  assign fifo_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign done_rise = i_tx_done && !done_prev_q;
  assign is_hdr    = i_rx_dv && (i_rx_byte == HEADER_BYTE);

  always_comb begin
    fx_byte = i_rx_byte;
    case (mode_q)
      2'd1:    fx_byte = (i_rx_byte > clip_q) ? clip_q : i_rx_byte;
      2'd2:    fx_byte = i_rx_byte & (8'hFF << crush_q);
      2'd3:    fx_byte = 8'hFF - i_rx_byte;
      default: fx_byte = i_rx_byte;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_WAIT_HDR: if (is_hdr) rx_state_d = RX_PAYLOAD;
      RX_PAYLOAD:  if (i_rx_dv && (fifo_full || rx_cnt_q == LAST_IDX)) rx_state_d = RX_WAIT_HDR;
      default:     rx_state_d = RX_WAIT_HDR;
    endcase
  end

  always_comb begin
    rx_cnt_d    = rx_cnt_q;
    mode_d      = mode_q;
    clip_d      = clip_q;
    crush_d     = crush_q;
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    push        = 1'b0;
    commit      = 1'b0;
    overflow_d  = 1'b0;
    if (rx_state_q == RX_WAIT_HDR) begin
      if (is_hdr) begin
        rx_cnt_d = 8'd0;
        mode_d   = i_mode;
        clip_d   = i_clip_level;
        crush_d  = i_crush_bits;
      end
    end else if (i_rx_dv) begin
      if (fifo_full) begin
        // Abort: discard the partial packet, committed packets stay intact.
        wr_ptr_d   = pkt_start_q;
        overflow_d = 1'b1;
      end else begin
        push     = 1'b1;
        wr_ptr_d = wr_ptr_q + PTRW'(1);
        rx_cnt_d = rx_cnt_q + 8'd1;
        if (rx_cnt_q == LAST_IDX) begin
          commit      = 1'b1;
          pkt_start_d = wr_ptr_q + PTRW'(1);
        end
      end
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE:      if (pending_q != '0) tx_state_d = TX_HDR;
      TX_HDR:       if (!i_tx_active) tx_state_d = TX_WAIT_HDR;
      TX_WAIT_HDR:  if (done_rise) tx_state_d = TX_DATA;
      TX_DATA:      if (!i_tx_active) tx_state_d = TX_WAIT_DATA;
      TX_WAIT_DATA: if (done_rise) tx_state_d = (tx_cnt_q == LEN8) ? TX_IDLE : TX_DATA;
      default:      tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_start  = (tx_state_q == TX_IDLE) && (pending_q != '0);
    tx_dv     = 1'b0;
    tx_byte_d = tx_byte_q;
    tx_cnt_d  = tx_start ? 8'd0 : tx_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    if (tx_state_q == TX_HDR && !i_tx_active) begin
      tx_dv     = 1'b1;
      tx_byte_d = HEADER_BYTE;
    end else if (tx_state_q == TX_DATA && !i_tx_active) begin
      tx_dv     = 1'b1;
      tx_byte_d = mem_q[rd_ptr_q[AW-1:0]];
      rd_ptr_d  = rd_ptr_q + PTRW'(1);
      tx_cnt_d  = tx_cnt_q + 8'd1;
    end
  end

  always_comb begin
    pending_d = pending_q;
    case ({commit, tx_start})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_state_q  <= RX_WAIT_HDR;
      tx_state_q  <= TX_IDLE;
      rx_cnt_q    <= 8'd0;
      tx_cnt_q    <= 8'd0;
      mode_q      <= 2'd0;
      clip_q      <= 8'd0;
      crush_q     <= 3'd0;
      wr_ptr_q    <= '0;
      pkt_start_q <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      done_prev_q <= 1'b0;
      overflow_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
    end else begin
      rx_state_q  <= rx_state_d;
      tx_state_q  <= tx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      mode_q      <= mode_d;
      clip_q      <= clip_d;
      crush_q     <= crush_d;
      wr_ptr_q    <= wr_ptr_d;
      pkt_start_q <= pkt_start_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      done_prev_q <= i_tx_done;
      overflow_q  <= overflow_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= fx_byte;
  end

  assign o_tx_dv       = tx_dv;
  assign o_tx_byte     = tx_byte_d;
  assign o_overflow    = overflow_q;
  assign o_pkt_pending = pending_q;
  assign o_busy        = (rx_state_q != RX_WAIT_HDR) || (tx_state_q != TX_IDLE);
endmodule
